// File: rtl/sa_read_arbiter_pkg.sv
// Shared definitions for the slave-side read arbiter: default field widths,
// AR FSM state encoding and the packed per-master slice helper.
package sa_read_arbiter_pkg;

  localparam int TRANS_MST_ID_W_DEF    = 5;
  localparam int TRANS_BURST_W_DEF     = 2;
  localparam int TRANS_DATA_LEN_W_DEF  = 3;
  localparam int TRANS_DATA_SIZE_W_DEF = 3;
  localparam int TRANS_WR_RESP_W_DEF   = 2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_HOLD = 1'b1
  } ar_state_e;

  // LSB position of master idx's field inside a packed per-master bus.
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sa_order_fifo.sv
// In-order FIFO of granted master indices; the head selects the R owner.
module sa_order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sa_read_arbiter.sv
// Round-robin AR arbiter with in-order R return routing for one slave port.
// Optional macro SA_AR_BACK_TO_BACK_EN allows a new grant while in HOLD.
module sa_read_arbiter
  import sa_read_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
  parameter int TRANS_BURST_W     = TRANS_BURST_W_DEF,
  parameter int TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
  parameter int TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
  parameter int TRANS_WR_RESP_W   = TRANS_WR_RESP_W_DEF,
  parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             dsp_RID_o,
  output logic [DATA_WIDTH-1:0]                 dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W-1:0]            dsp_RRESP_o,
  output logic                                  dsp_RLAST_o,
  output logic [MST_AMT-1:0]                    dsp_RVALID_o,
  input  logic [MST_AMT-1:0]                    dsp_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o,
  output logic                                  order_full_o
);

  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; AR READY toward the dispatchers is only raised for the winner.

  logic [TRANS_MST_ID_W-1:0]    arid_a    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        araddr_a  [MST_AMT];
  logic [TRANS_BURST_W-1:0]     arburst_a [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  arlen_a   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] arsize_a  [MST_AMT];

  for (genvar m = 0; m < MST_AMT; m++) begin : g_unpack
    assign arid_a[m]    = dsp_ARID_i[field_lsb(m, TRANS_MST_ID_W) +: TRANS_MST_ID_W];
    assign araddr_a[m]  = dsp_ARADDR_i[field_lsb(m, ADDR_WIDTH) +: ADDR_WIDTH];
    assign arburst_a[m] = dsp_ARBURST_i[field_lsb(m, TRANS_BURST_W) +: TRANS_BURST_W];
    assign arlen_a[m]   = dsp_ARLEN_i[field_lsb(m, TRANS_DATA_LEN_W) +: TRANS_DATA_LEN_W];
    assign arsize_a[m]  = dsp_ARSIZE_i[field_lsb(m, TRANS_DATA_SIZE_W) +: TRANS_DATA_SIZE_W];
  end

  ar_state_e                    ar_state_q, ar_state_d;
  logic [MST_ID_W-1:0]          rr_q, rr_d;
  logic [MST_ID_W-1:0]          winner, win_hi, win_lo;
  logic                         found_hi, any_req;
  logic                         ar_can_grant, grant;
  logic [TRANS_MST_ID_W-1:0]    s_arid_q;
  logic [ADDR_WIDTH-1:0]        s_araddr_q;
  logic [TRANS_BURST_W-1:0]     s_arburst_q;
  logic [TRANS_DATA_LEN_W-1:0]  s_arlen_q;
  logic [TRANS_DATA_SIZE_W-1:0] s_arsize_q;

  logic [MST_ID_W-1:0] fifo_head;
  logic                fifo_empty, fifo_full, fifo_pop;
  logic [CNT_W-1:0]    fifo_count;

  // Descending scan: win_lo ends as the lowest requester overall, win_hi as
  // the lowest at or above the pointer; win_lo covers the wrap-around case.
  always_comb begin
    found_hi = 1'b0;
    any_req  = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      if (dsp_ARVALID_i[i]) begin
        any_req = 1'b1;
        win_lo  = MST_ID_W'(i);
        if (i >= int'(rr_q)) begin
          found_hi = 1'b1;
          win_hi   = MST_ID_W'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Gated by reset so requests held during reset are never acknowledged.
  assign ar_can_grant = ARESETn_i & any_req & ~fifo_full;

  always_comb begin
    ar_state_d = ar_state_q;
    grant      = 1'b0;
    case (ar_state_q)
      AR_IDLE: begin
        if (ar_can_grant) begin
          grant      = 1'b1;
          ar_state_d = AR_HOLD;
        end
      end
      AR_HOLD: begin
        if (s_ARREADY_i) begin
`ifdef SA_AR_BACK_TO_BACK_EN
          if (ar_can_grant) grant = 1'b1;
          else              ar_state_d = AR_IDLE;
`else
          ar_state_d = AR_IDLE;
`endif
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    dsp_ARREADY_o = '0;
    if (grant) dsp_ARREADY_o[winner] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (winner == MST_ID_W'(MST_AMT - 1)) ? '0 : winner + MST_ID_W'(1);
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      ar_state_q  <= AR_IDLE;
      rr_q        <= '0;
      s_arid_q    <= '0;
      s_araddr_q  <= '0;
      s_arburst_q <= '0;
      s_arlen_q   <= '0;
      s_arsize_q  <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      rr_q       <= rr_d;
      if (grant) begin
        s_arid_q    <= arid_a[winner];
        s_araddr_q  <= araddr_a[winner];
        s_arburst_q <= arburst_a[winner];
        s_arlen_q   <= arlen_a[winner];
        s_arsize_q  <= arsize_a[winner];
      end
    end
  end

  assign s_ARVALID_o = (ar_state_q == AR_HOLD);
  assign s_ARID_o    = s_arid_q;
  assign s_ARADDR_o  = s_araddr_q;
  assign s_ARBURST_o = s_arburst_q;
  assign s_ARLEN_o   = s_arlen_q;
  assign s_ARSIZE_o  = s_arsize_q;

  sa_order_fifo #(
    .DEPTH (OUTSTANDING_AMT),
    .W     (MST_ID_W),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk_i   (ACLK_i),
    .rst_ni  (ARESETn_i),
    .push_i  (grant),
    .pop_i   (fifo_pop),
    .din_i   (winner),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign order_full_o = (fifo_count == CNT_W'(OUTSTANDING_AMT));

  // Only the head owner sees RVALID and only its RREADY reaches the slave.
  always_comb begin
    dsp_RVALID_o = '0;
    s_RREADY_o   = 1'b0;
    if (!fifo_empty) begin
      dsp_RVALID_o[fifo_head] = s_RVALID_i;
      s_RREADY_o              = dsp_RREADY_i[fifo_head];
    end
  end

  assign fifo_pop    = s_RVALID_i & s_RREADY_o & s_RLAST_i;
  assign dsp_RID_o   = s_RID_i;
  assign dsp_RDATA_o = s_RDATA_i;
  assign dsp_RRESP_o = s_RRESP_i;
  assign dsp_RLAST_o = s_RLAST_i;

endmodule

// File: tb/tb_sa_read_arbiter.sv
// Directed bench for sa_read_arbiter (default build, MST_AMT=2, depth 4).
module tb_sa_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  dsp_arid;
  logic [63:0] dsp_araddr;
  logic [3:0]  dsp_arburst;
  logic [5:0]  dsp_arlen;
  logic [5:0]  dsp_arsize;
  logic [1:0]  dsp_arvalid;
  logic [1:0]  dsp_arready;
  logic [4:0]  dsp_rid;
  logic [31:0] dsp_rdata;
  logic [1:0]  dsp_rresp;
  logic        dsp_rlast;
  logic [1:0]  dsp_rvalid;
  logic [1:0]  dsp_rready;
  logic [4:0]  s_arid;
  logic [31:0] s_araddr;
  logic [1:0]  s_arburst;
  logic [2:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic        s_arvalid;
  logic        s_arready;
  logic [4:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic        order_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_read_arbiter dut (
    .ACLK_i        (clk),
    .ARESETn_i     (rst_n),
    .dsp_ARID_i    (dsp_arid),
    .dsp_ARADDR_i  (dsp_araddr),
    .dsp_ARBURST_i (dsp_arburst),
    .dsp_ARLEN_i   (dsp_arlen),
    .dsp_ARSIZE_i  (dsp_arsize),
    .dsp_ARVALID_i (dsp_arvalid),
    .dsp_ARREADY_o (dsp_arready),
    .dsp_RID_o     (dsp_rid),
    .dsp_RDATA_o   (dsp_rdata),
    .dsp_RRESP_o   (dsp_rresp),
    .dsp_RLAST_o   (dsp_rlast),
    .dsp_RVALID_o  (dsp_rvalid),
    .dsp_RREADY_i  (dsp_rready),
    .s_ARID_o      (s_arid),
    .s_ARADDR_o    (s_araddr),
    .s_ARBURST_o   (s_arburst),
    .s_ARLEN_o     (s_arlen),
    .s_ARSIZE_o    (s_arsize),
    .s_ARVALID_o   (s_arvalid),
    .s_ARREADY_i   (s_arready),
    .s_RID_i       (s_rid),
    .s_RDATA_i     (s_rdata),
    .s_RRESP_i     (s_rresp),
    .s_RLAST_i     (s_rlast),
    .s_RVALID_i    (s_rvalid),
    .s_RREADY_o    (s_rready),
    .order_full_o  (order_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    s_rvalid = 1'b1;
    s_rdata  = data;
    s_rlast  = last;
  endtask

  initial begin
    rst_n       = 1'b0;
    dsp_arid    = {5'h11, 5'h03};
    dsp_araddr  = {32'h2000_0000, 32'h1000_0000};
    dsp_arburst = {2'b01, 2'b10};
    dsp_arlen   = {3'd1, 3'd3};
    dsp_arsize  = {3'd2, 3'd1};
    dsp_arvalid = 2'b11;
    dsp_rready  = 2'b00;
    s_arready   = 1'b0;
    s_rid       = 5'h03;
    s_rdata     = '0;
    s_rresp     = 2'b00;
    s_rlast     = 1'b0;
    s_rvalid    = 1'b0;

    // Reset with requests pending: nothing acknowledged, everything idle.
    #2;
    chk("rst_arready", 64'(dsp_arready), 64'h0);
    chk("rst_arvalid", 64'(s_arvalid), 64'h0);
    chk("rst_arid", 64'(s_arid), 64'h0);
    chk("rst_araddr", 64'(s_araddr), 64'h0);
    chk("rst_full", 64'(order_full), 64'h0);
    chk("rst_rvalid", 64'(dsp_rvalid), 64'h0);
    chk("rst_rready", 64'(s_rready), 64'h0);
    step();
    chk("rst_arready_edge", 64'(dsp_arready), 64'h0);
    rst_n = 1'b1;

    // Contention: alternating grants, one every two cycles, until full.
    s_arready = 1'b1;
    #1;
    chk("g1_ready", 64'(dsp_arready), 64'h1);
    step();
    chk("g1_arvalid", 64'(s_arvalid), 64'h1);
    chk("g1_arid", 64'(s_arid), 64'h03);
    chk("g1_araddr", 64'(s_araddr), 64'h1000_0000);
    chk("g1_arburst", 64'(s_arburst), 64'h2);
    chk("g1_arlen", 64'(s_arlen), 64'h3);
    chk("g1_arsize", 64'(s_arsize), 64'h1);
    chk("hold_ready", 64'(dsp_arready), 64'h0);
    step();
    chk("idle_arvalid", 64'(s_arvalid), 64'h0);
    chk("g2_ready", 64'(dsp_arready), 64'h2);
    step();
    chk("g2_arvalid", 64'(s_arvalid), 64'h1);
    chk("g2_arid", 64'(s_arid), 64'h11);
    chk("g2_araddr", 64'(s_araddr), 64'h2000_0000);
    chk("g2_arburst", 64'(s_arburst), 64'h1);
    chk("g2_arsize", 64'(s_arsize), 64'h2);
    step();
    chk("g3_ready", 64'(dsp_arready), 64'h1);
    step();
    chk("g3_arid", 64'(s_arid), 64'h03);
    chk("g3_full", 64'(order_full), 64'h0);
    step();
    chk("g4_ready", 64'(dsp_arready), 64'h2);
    step();
    chk("g4_arid", 64'(s_arid), 64'h11);
    chk("g4_full", 64'(order_full), 64'h1);
    step();
    chk("full_ready", 64'(dsp_arready), 64'h0);
    chk("full_flag", 64'(order_full), 64'h1);
    chk("full_arvalid", 64'(s_arvalid), 64'h0);
    step();
    chk("full_ready2", 64'(dsp_arready), 64'h0);

    // Single-beat return pops the head; the slot frees only after the edge.
    dsp_rready = 2'b01;
    s_rid      = 5'h03;
    s_rresp    = 2'b10;
    beat(32'hAAAA_0001, 1'b1);
    #1;
    chk("pop_rvalid", 64'(dsp_rvalid), 64'h1);
    chk("pop_rready", 64'(s_rready), 64'h1);
    chk("pop_rid", 64'(dsp_rid), 64'h03);
    chk("pop_rdata", 64'(dsp_rdata), 64'hAAAA_0001);
    chk("pop_rresp", 64'(dsp_rresp), 64'h2);
    chk("pop_rlast", 64'(dsp_rlast), 64'h1);
    chk("pop_same_cycle_ready", 64'(dsp_arready), 64'h0);
    step();
    s_rvalid = 1'b0;
    #1;
    chk("after_pop_ready", 64'(dsp_arready), 64'h1);
    chk("after_pop_full", 64'(order_full), 64'h0);
    chk("next_head_rvalid_idle", 64'(dsp_rvalid), 64'h0);

    dsp_arvalid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst2_full", 64'(order_full), 64'h0);
    chk("rst2_arvalid", 64'(s_arvalid), 64'h0);
    step();
    rst_n = 1'b1;

    // In-order routing: M0 burst of 4, M1 burst of 2, with backpressure.
    dsp_arvalid = 2'b01;
    #1;
    chk("r_g0_ready", 64'(dsp_arready), 64'h1);
    step();
    dsp_arvalid = 2'b10;
    #1;
    chk("r_g0_arlen", 64'(s_arlen), 64'h3);
    step();
    chk("r_g1_ready", 64'(dsp_arready), 64'h2);
    step();
    dsp_arvalid = 2'b00;
    chk("r_g1_arlen", 64'(s_arlen), 64'h1);
    chk("r_g1_arid", 64'(s_arid), 64'h11);
    step();

    dsp_rready = 2'b10;
    beat(32'hB000_0001, 1'b0);
    #1;
    chk("bp_rready", 64'(s_rready), 64'h0);
    chk("bp_rvalid", 64'(dsp_rvalid), 64'h1);
    step();
    chk("bp_held_rvalid", 64'(dsp_rvalid), 64'h1);
    chk("bp_held_data", 64'(dsp_rdata), 64'hB000_0001);
    dsp_rready = 2'b01;
    #1;
    chk("bp_release", 64'(s_rready), 64'h1);
    step();
    dsp_rready = 2'b11;
    for (int b = 2; b <= 6; b++) begin
      beat(32'hB000_0000 + 32'(b), (b == 4) || (b == 6));
      #1;
      chk($sformatf("beat%0d_rvalid", b), 64'(dsp_rvalid), (b <= 4) ? 64'h1 : 64'h2);
      chk($sformatf("beat%0d_rready", b), 64'(s_rready), 64'h1);
      step();
    end
    s_rlast = 1'b0;
    #1;
    chk("drained_rvalid", 64'(dsp_rvalid), 64'h0);
    chk("drained_rready", 64'(s_rready), 64'h0);
    s_rvalid = 1'b0;

    // Reset during beat 2 of a 4-beat burst drops the outstanding entry.
    dsp_arvalid = 2'b01;
    #1;
    chk("m_ready", 64'(dsp_arready), 64'h1);
    step();
    dsp_arvalid = 2'b00;
    step();
    dsp_rready = 2'b01;
    beat(32'hC000_0001, 1'b0);
    #1;
    chk("m_b1_rvalid", 64'(dsp_rvalid), 64'h1);
    step();
    beat(32'hC000_0002, 1'b0);
    #1;
    chk("m_b2_rvalid", 64'(dsp_rvalid), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("m_rst_rvalid", 64'(dsp_rvalid), 64'h0);
    chk("m_rst_rready", 64'(s_rready), 64'h0);
    chk("m_rst_full", 64'(order_full), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("m_post_rvalid", 64'(dsp_rvalid), 64'h0);
    chk("m_post_rready", 64'(s_rready), 64'h0);
    step();
    chk("m_post2_rvalid", 64'(dsp_rvalid), 64'h0);
    s_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
